// File: rtl/mac_arbiter.sv
// Round-robin arbiter feeding one shared two-stage unsigned multiply-add (a*b+c) unit;
// each result leaves on a single valid/ready port, tagged with the index of its requester.
module mac_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int DATA_WIDTH_OUT = 17,
  parameter int ID_WIDTH       = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_b,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_c,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic [DATA_WIDTH_OUT-1:0]      res_data,
  output logic [ID_WIDTH-1:0]            res_id,
  output logic                           busy
);

  // Wide enough for the exact a*b+c, and never narrower than the output.
  localparam int CALC_W = (DATA_WIDTH_OUT > 2*DATA_WIDTH+1) ? DATA_WIDTH_OUT : 2*DATA_WIDTH+1;

  logic [DATA_WIDTH-1:0]     lane_a [NUM_REQ];
  logic [DATA_WIDTH-1:0]     lane_b [NUM_REQ];
  logic [DATA_WIDTH-1:0]     lane_c [NUM_REQ];

  logic [ID_WIDTH-1:0]       rr_ptr_reg;
  logic                      s1_valid_reg;
  logic [DATA_WIDTH-1:0]     s1_a_reg;
  logic [DATA_WIDTH-1:0]     s1_b_reg;
  logic [DATA_WIDTH-1:0]     s1_c_reg;
  logic [ID_WIDTH-1:0]       s1_id_reg;
  logic                      res_valid_reg;
  logic [DATA_WIDTH_OUT-1:0] res_data_reg;
  logic [ID_WIDTH-1:0]       res_id_reg;

  logic                      en;
  logic                      grant_found;
  logic [ID_WIDTH-1:0]       grant_id;
  logic                      take;
  logic [ID_WIDTH-1:0]       rr_ptr_next;
  logic [CALC_W-1:0]         mac_full;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      assign lane_a[gi] = req_a[gi*DATA_WIDTH +: DATA_WIDTH];
      assign lane_b[gi] = req_b[gi*DATA_WIDTH +: DATA_WIDTH];
      assign lane_c[gi] = req_c[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  function automatic logic [ID_WIDTH-1:0] wrap_idx(input logic [ID_WIDTH-1:0] base, input int offs);
    int sum;
    sum = int'(base) + offs;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return ID_WIDTH'(sum);
  endfunction

  assign en = !res_valid_reg || res_ready;

  // First valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_found && req_valid[wrap_idx(rr_ptr_reg, k)]) begin
        grant_found = 1'b1;
        grant_id    = wrap_idx(rr_ptr_reg, k);
      end
    end
  end

  assign take        = en && grant_found && !reset;
  assign rr_ptr_next = (grant_id == ID_WIDTH'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;

  always_comb begin
    req_ready = '0;
    if (take) req_ready[grant_id] = 1'b1;
  end

  assign mac_full = CALC_W'(s1_a_reg) * CALC_W'(s1_b_reg) + CALC_W'(s1_c_reg);

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_reg    <= '0;
      s1_valid_reg  <= 1'b0;
      s1_a_reg      <= '0;
      s1_b_reg      <= '0;
      s1_c_reg      <= '0;
      s1_id_reg     <= '0;
      res_valid_reg <= 1'b0;
      res_data_reg  <= '0;
      res_id_reg    <= '0;
    end else if (en) begin
      s1_valid_reg <= take;
      if (take) begin
        s1_a_reg   <= lane_a[grant_id];
        s1_b_reg   <= lane_b[grant_id];
        s1_c_reg   <= lane_c[grant_id];
        s1_id_reg  <= grant_id;
        rr_ptr_reg <= rr_ptr_next;
      end
      res_valid_reg <= s1_valid_reg;
      // Bubbles leave the last result's data and id untouched.
      if (s1_valid_reg) begin
        res_data_reg <= mac_full[DATA_WIDTH_OUT-1:0];
        res_id_reg   <= s1_id_reg;
      end
    end
  end

  assign res_valid = res_valid_reg;
  assign res_data  = res_data_reg;
  assign res_id    = res_id_reg;
  assign busy      = s1_valid_reg || res_valid_reg;

endmodule

// File: tb/tb_mac_arbiter.sv
// Bench for mac_arbiter: a cycle model predicts grants and handshakes; a queue scoreboard checks results.
module tb_mac_arbiter;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_a = '0, req_b = '0, req_c = '0;
  logic        res_ready = 1'b1;
  logic [3:0]  req_ready;
  logic        res_valid;
  logic [16:0] res_data;
  logic [1:0]  res_id;
  logic        busy;
  logic [3:0]  req_ready12;
  logic        res_valid12;
  logic [11:0] res_data12;
  logic [1:0]  res_id12;
  logic        busy12;

  int n_cmp = 0, n_err = 0, cyc = 0;

  always #5 clk = ~clk;

  mac_arbiter dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_id(res_id), .busy(busy)
  );

  mac_arbiter #(.DATA_WIDTH_OUT(12)) dut12 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready12),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .res_valid(res_valid12), .res_ready(res_ready), .res_data(res_data12),
    .res_id(res_id12), .busy(busy12)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model state and scoreboard.
  int   m_ptr = 0;
  bit   m_s1v = 0, m_rv = 0, m_en;
  int   m_g;
  logic [3:0] exp_ready;
  int   exp_data_q[$], exp_id_q[$];
  int   grant_log[$];
  int   rl_data[$], rl_id[$], rl_cyc[$];

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      check("rst_req_ready", int'(req_ready), 0);
      m_ptr = 0; m_s1v = 0; m_rv = 0;
      exp_data_q.delete(); exp_id_q.delete();
    end else begin
      m_en = !m_rv || res_ready;
      m_g = -1;
      for (int k = 0; k < N; k++)
        if (m_g < 0 && req_valid[(m_ptr + k) % N]) m_g = (m_ptr + k) % N;
      exp_ready = '0;
      if (m_en && m_g >= 0) exp_ready[m_g] = 1'b1;
      check("req_ready", int'(req_ready), int'(exp_ready));
      check("res_valid", int'(res_valid), int'(m_rv));
      check("busy", int'(busy), int'(m_s1v || m_rv));
      for (int i = 0; i < N; i++)
        if (req_ready[i] && req_valid[i]) grant_log.push_back(i);
      if (res_valid && res_ready) begin
        rl_data.push_back(int'(res_data)); rl_id.push_back(int'(res_id)); rl_cyc.push_back(cyc);
      end
      if (m_rv) begin
        check("sb_nonempty", int'(exp_data_q.size() > 0), 1);
        if (exp_data_q.size() > 0) begin
          check("sb_data", int'(res_data), exp_data_q[0]);
          check("sb_id", int'(res_id), exp_id_q[0]);
          if (res_ready) begin
            void'(exp_data_q.pop_front()); void'(exp_id_q.pop_front());
          end
        end
      end
      if (m_en) begin
        m_rv  = m_s1v;
        m_s1v = (m_g >= 0);
        if (m_g >= 0) begin
          exp_data_q.push_back((int'(req_a[m_g*8 +: 8]) * int'(req_b[m_g*8 +: 8]) + int'(req_c[m_g*8 +: 8])) % 131072);
          exp_id_q.push_back(m_g);
          m_ptr = (m_g + 1) % N;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input int a, input int b, input int c);
    req_a[i*8 +: 8] = 8'(a);
    req_b[i*8 +: 8] = 8'(b);
    req_c[i*8 +: 8] = 8'(c);
  endtask

  task automatic clear_logs;
    grant_log.delete(); rl_data.delete(); rl_id.delete(); rl_cyc.delete();
  endtask

  task automatic do_reset;
    reset = 1'b1; req_valid = '0; res_ready = 1'b1;
    step(1);
    reset = 1'b0;
    clear_logs();
  endtask

  task automatic rr_lanes;
    for (int i = 0; i < N; i++) set_lane(i, i + 1, 2, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    step(2);
    #1;
    check("reset_res_valid", int'(res_valid), 0);
    check("reset_res_data", int'(res_data), 0);
    check("reset_res_id", int'(res_id), 0);
    check("reset_busy", int'(busy), 0);
    reset = 1'b0;
    clear_logs();

    // Single request from requester 1
    set_lane(1, 3, 5, 7); req_valid = 4'b0010; #1;
    check("single_ready", int'(req_ready), 2);
    step(1); req_valid = '0; #1;
    check("single_t1_valid", int'(res_valid), 0);
    check("single_t1_busy", int'(busy), 1);
    step(1);
    check("single_t2_valid", int'(res_valid), 1);
    check("single_t2_data", int'(res_data), 22);
    check("single_t2_id", int'(res_id), 1);
    check("single_t2_busy", int'(busy), 1);
    step(1);
    check("single_t3_valid", int'(res_valid), 0);
    check("single_t3_busy", int'(busy), 0);
    $display("single request: data=22 id=1 checked");

    // Round robin, all requesters continuously valid
    do_reset(); rr_lanes(); req_valid = 4'hF;
    step(5); req_valid = '0; step(4);
    check("rr_grant_count", grant_log.size(), 5);
    check("rr_res_count", rl_data.size(), 5);
    for (int k = 0; k < 5; k++) begin
      if (k < grant_log.size()) check("rr_grant_order", grant_log[k], k % N);
      if (k < rl_data.size()) begin
        check("rr_res_data", rl_data[k], 2 * (k % N + 1));
        check("rr_res_id", rl_id[k], k % N);
        if (k > 0) check("rr_res_gap", rl_cyc[k] - rl_cyc[k-1], 1);
      end
    end
    $display("round robin: %0d grants, %0d results", grant_log.size(), rl_data.size());

    // Backpressure for 3 cycles after the first result
    do_reset(); rr_lanes(); req_valid = 4'hF;
    step(2); res_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #1;
      check("stall_req_ready", int'(req_ready), 0);
      check("stall_valid", int'(res_valid), 1);
      check("stall_data", int'(res_data), 2);
      check("stall_id", int'(res_id), 0);
      step(1);
    end
    res_ready = 1'b1;
    step(6); req_valid = '0; step(5);
    check("bp_grant_count", grant_log.size(), 8);
    check("bp_res_count", rl_data.size(), 8);
    for (int k = 0; k < rl_data.size() && k < 8; k++) begin
      check("bp_res_data", rl_data[k], 2 * (k % N + 1));
      check("bp_res_id", rl_id[k], k % N);
    end
    $display("backpressure: %0d results after 3-cycle stall", rl_data.size());

    // Maximum operands, full and truncated output widths
    do_reset(); set_lane(0, 255, 255, 255); req_valid = 4'b0001;
    step(1); req_valid = '0; step(1); #1;
    check("max_valid", int'(res_valid), 1);
    check("max_data", int'(res_data), 65280);
    check("max12_valid", int'(res_valid12), 1);
    check("max12_data", int'(res_data12), 3840);
    step(3);
    $display("max values: data=%0d data12=%0d", 65280, 3840);

    // Sparse requests with pointer wrap
    do_reset(); set_lane(0, 4, 4, 1); set_lane(2, 9, 9, 9);
    req_valid = 4'b0100; step(1);
    req_valid = 4'b0101; #1;
    check("wrap_ready", int'(req_ready), 1);
    step(2); req_valid = '0; step(4);
    check("wrap_grant_count", grant_log.size(), 3);
    for (int k = 0; k < grant_log.size() && k < 3; k++)
      check("wrap_grant_order", grant_log[k], (k == 1) ? 0 : 2);
    check("wrap_res_count", rl_data.size(), 3);
    if (rl_data.size() > 1) check("wrap_res1_data", rl_data[1], 17);
    $display("sparse wrap: grants observed %0d", grant_log.size());

    // Reset with two items in flight
    do_reset(); rr_lanes(); req_valid = 4'hF;
    step(2);
    reset = 1'b1; step(1);
    check("midrst_valid", int'(res_valid), 0);
    check("midrst_busy", int'(busy), 0);
    reset = 1'b0; #1;
    check("midrst_next_grant", int'(req_ready), 1);
    clear_logs();
    step(1); req_valid = '0; step(4);
    check("midrst_res_count", rl_data.size(), 1);
    if (rl_data.size() > 0) begin
      check("midrst_res_data", rl_data[0], 2);
      check("midrst_res_id", rl_id[0], 0);
    end
    $display("reset mid-op: %0d results after reset", rl_data.size());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mac_arbiter.md
Name: mac_arbiter

Overview:
- Shares one pipelined unsigned multiply-add unit (a*b+c) between NUM_REQ requesters using round-robin arbitration.
- Each requester presents an operand triple with a valid/ready handshake.
- The arbiter issues one triple per cycle into a 2-stage MAC pipeline.
- It returns the result tagged with the requester index on a single valid/ready output port.
- Sits between the compute clients and the shared MAC datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 8, operand width of a, b, c.
- DATA_WIDTH_OUT, 17, result width; >= 2*DATA_WIDTH+1 means overflow is impossible.
- ID_WIDTH, 2, width of requester index; must satisfy 2**ID_WIDTH >= NUM_REQ.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  bit i: requester i presents operands.
- req_ready  out  NUM_REQ  bit i: requester i accepted this cycle (one-hot or zero).
- req_a  in  NUM_REQ*DATA_WIDTH  lane i at [i*DATA_WIDTH +: DATA_WIDTH].
- req_b  in  NUM_REQ*DATA_WIDTH  same packing as req_a.
- req_c  in  NUM_REQ*DATA_WIDTH  same packing as req_a.
- res_valid  out  1  res_data/res_id valid.
- res_ready  in  1  consumer accepts result.
- res_data  out  DATA_WIDTH_OUT  a*b+c.
- res_id  out  ID_WIDTH  index of the originating requester.
- busy  out  1  any pipeline stage holds a valid item.

Behaviour:

Reset (reset=1 at an edge):
- res_valid=0, res_data=0, res_id=0.
- Both stage valids cleared; rr_ptr=0; busy=0.
- req_ready is 0 while reset is high.
- Reset mid-operation discards in-flight items with no output.

Advance enable:
- en = !res_valid || res_ready.
- All stages shift only when en=1.
- When en=0, every register holds and req_ready is all-zero.

Arbitration (combinational, evaluated when en=1):
- Search req_valid starting at index rr_ptr, wrapping modulo NUM_REQ.
- The first set bit g is granted: req_ready[g]=1, all other bits 0.
- req_ready never depends on res_valid of the same requester; it depends only on req_valid, rr_ptr and en.
- A transfer occurs when req_valid[g] && req_ready[g].
- On a transfer, rr_ptr <= (g+1) mod NUM_REQ. Otherwise rr_ptr holds.
- With no req_valid bit set, nothing is granted and a bubble enters stage 1.

Stage 1 (en=1):
- s1_valid <= transfer.
- On a transfer, also capture a, b, c and id=g.

Stage 2 / output (en=1):
- res_valid <= s1_valid.
- If s1_valid: res_data <= zero-extend(s1_a)*zero-extend(s1_b) + zero-extend(s1_c), computed at full width and truncated to the low DATA_WIDTH_OUT bits; res_id <= s1_id.
- When s1_valid=0, res_data/res_id hold their previous values.

Latency and throughput:
- A transfer in cycle t produces res_valid=1 in cycle t+2.
- Throughput is 1 result/cycle with res_ready held high.
- While res_valid=1 && res_ready=0, res_data/res_id/res_valid are stable and no new request is accepted.
- busy = s1_valid || res_valid.

Boundary conditions:
- A requester dropping req_valid without a grant is legal; it is simply not served.
- Simultaneous res_ready and a new grant in the same cycle: the output pops and the pipeline shifts in the same edge, with no bubble.
- rr_ptr wraps from NUM_REQ-1 to 0.
- Fairness: a continuously valid requester waits at most NUM_REQ-1 grants.

Test Plan:
- Single request: only req 1 valid with a=3, b=5, c=7, res_ready=1. Required: transfer in cycle t, res_valid in cycle t+2 with res_data=22, res_id=1, busy high for 2 cycles.
- Round robin: all 4 requesters valid continuously, lane i operands a=i+1, b=2, c=0. Required: grant order 0,1,2,3,0,...; results 2,4,6,8,2 on consecutive cycles, ids 0,1,2,3,0.
- Backpressure: as the round-robin case, but res_ready=0 for 3 cycles after the first result. Required: res_data=2/res_id=0 held stable, req_ready=0 during the stall, then the stream resumes with no loss or duplication.
- Max values: a=b=c=255. Required: res_data=65280. With DATA_WIDTH_OUT=12 override, res_data=65280 mod 4096=3840.
- Sparse/wrap: rr_ptr=3 after granting req 2, then only req 0 and req 2 valid. Required: req 0 is granted first (wrap), then req 2.
- Reset mid-op: assert reset for 1 cycle with 2 items in flight. Required: res_valid=0, busy=0 the next cycle, no stale result ever appears, and the next grant goes to req 0.
